adc_sample_packer: RTL
======================

// Module: adc_sample_packer
// PURPOSE
//  Sits upstream of the 64-bit DMA data producer, in the data_clk domain.
//  - Decimates the ADC conversion stream and latches all channels into a pending buffer.
//  - Presents each captured sample as WORDS consecutive 64-bit words, selected by word_idx.
//  - Raises new_sample to start the producer's DATA burst; double buffering lets capture overlap drain.
// PARAMETERS
//  N_CHAN        64   ADC channels per conversion
//  SAMPLE_WIDTH  16   bits per channel
//  DATA_WIDTH    64   output word width; WORDS = N_CHAN*SAMPLE_WIDTH/DATA_WIDTH (default 16)
//  DECIM_WIDTH   16   width of decimation ratio
// PORTS
//  data_clk     in   1                      40 MHz clock; all logic on the rising edge
//  user_rstn    in   1                      reset, asynchronous, active-low
//  acq_ena      in   1                      acquisition enable; low = synchronous flush
//  decim        in   DECIM_WIDTH            keep 1 of every decim+1 conversions (0 = keep all)
//  adc_valid    in   1                      1-cycle strobe: adc_data holds a new conversion
//  adc_data     in   N_CHAN*SAMPLE_WIDTH    channel c at bits [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//  rd_ack       in   1                      consumer accepted current word (its tvalid & tready)
//  new_sample   out  1                      drain buffer loaded, burst not yet started (level)
//  word_data    out  DATA_WIDTH             current word of drain buffer
//  word_idx     out  log2(WORDS)            index of current word
//  overrun      out  1                      sticky: a capture was dropped
//  sample_cnt   out  32                     captures accepted since enable
// BEHAVIOUR
//  Reset (user_rstn low): all outputs 0; state EMPTY; pending_v=0; dec_cnt=0.
//  Flush (acq_ena low, synchronous): same values as reset; adc_valid ignored; overrun cleared.
//  Decimation: on adc_valid, if dec_cnt==decim then capture and dec_cnt<=0, else dec_cnt+1.
//  - decim changed mid-run: takes effect on the next compare.
//  Capture: writes adc_data to pending buffer, sets pending_v, sample_cnt+1 (wraps at 2^32).
//  - If pending_v=1 and pending is not freed the same cycle: capture dropped, overrun<=1,
//    sample_cnt and pending unchanged.
//  Word packing: word k = drain[k*DATA_WIDTH +: DATA_WIDTH], i.e. ch[4k] in bits [15:0],
//    ch[4k+3] in bits [63:48].
//  word_data is combinational from drain buffer and word_idx; zero added latency.
//  FSM (state register, next-state on data_clk):
//  - EMPTY: word_idx=0, new_sample=0. If pending_v: drain<=pending, pending_v<=0, ->READY.
//    First new_sample one cycle after pending loaded; capture-to-new_sample latency is 2 cycles.
//  - READY: new_sample=1, held until the burst starts. On rd_ack: word_idx<=1, ->DRAIN.
//  - DRAIN: new_sample=0. On rd_ack: word_idx+1. On rd_ack with word_idx==WORDS-1:
//    - pending_v=1: drain<=pending, pending_v<=0, word_idx<=0, ->READY (no gap cycle).
//    - pending_v=0: word_idx<=0, ->EMPTY.
//  Boundaries and ordering:
//  - rd_ack in EMPTY is ignored.
//  - Capture in the same cycle as the final rd_ack: pending is freed first, the capture
//    lands in it, no overrun.
//  - Capture in the same cycle as the EMPTY->READY transfer behaves the same way.
//  - Consumer stalls (rd_ack low) hold word_idx and word_data stable indefinitely.
//  - acq_ena falling mid-burst abandons the burst: ->EMPTY, word_idx=0.
//  - user_rstn asserted mid-operation: outputs 0 immediately (asynchronous).
//  - Burst length WORDS divides the producer packet length (2048), so bursts never straddle
//    a packet boundary.
// TESTING
//  T1 decim=0, one adc_valid with ch[c]=c:
//     new_sample rises 2 cycles later; 16 rd_acks give word0=0x0003_0002_0001_0000,
//     word15=0x003F_003E_003D_003C; then EMPTY, sample_cnt=1.
//  T2 decim=3, 12 adc_valid strobes: exactly 3 captures (strobes 4, 8, 12); sample_cnt=3.
//  T3 rd_ack held low during READY/DRAIN, 2 further captures:
//     first fills pending, second sets overrun=1, sample_cnt=2; acq_ena low clears overrun.
//  T4 capture coincident with final rd_ack:
//     overrun stays 0; next cycle new_sample=1, word_idx=0 holding the new data.
//  T5 acq_ena dropped at word_idx=7: next cycle state EMPTY, word_idx=0, new_sample=0,
//     sample_cnt=0.
//  T6 user_rstn pulsed low mid-DRAIN: all outputs 0 within the same cycle, no clock edge needed.

Source files
------------

// File: rtl/adc_sample_packer.sv
// adc_sample_packer
// Decimates the ADC conversion stream into a pending buffer, then hands each
// captured sample to the 64-bit DMA producer as WORDS consecutive words.
// Pending + drain buffers form a double buffer so capture overlaps drain.
module adc_sample_packer #(
  parameter  int N_CHAN       = 64,
  parameter  int SAMPLE_WIDTH = 16,
  parameter  int DATA_WIDTH   = 64,
  parameter  int DECIM_WIDTH  = 16,
  localparam int SAMPLE_BITS  = N_CHAN * SAMPLE_WIDTH,
  localparam int WORDS        = SAMPLE_BITS / DATA_WIDTH,
  localparam int IDX_W        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                   data_clk,
  input  logic                   user_rstn,
  input  logic                   acq_ena,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic                   adc_valid,
  input  logic [SAMPLE_BITS-1:0] adc_data,
  input  logic                   rd_ack,
  output logic                   new_sample,
  output logic [DATA_WIDTH-1:0]  word_data,
  output logic [IDX_W-1:0]       word_idx,
  output logic                   overrun,
  output logic [31:0]            sample_cnt
);

  // EMPTY: nothing to drain; READY: drain loaded, burst not started;
  // DRAIN: burst in progress, word_idx walks 1..WORDS-1.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READY = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 state_q,      state_d;
  logic [IDX_W-1:0]       word_idx_q,   word_idx_d;
  logic [SAMPLE_BITS-1:0] drain_q,      drain_d;
  logic [SAMPLE_BITS-1:0] pending_q,    pending_d;
  logic                   pending_v_q,  pending_v_d;
  logic [DECIM_WIDTH-1:0] dec_cnt_q,    dec_cnt_d;
  logic                   overrun_q,    overrun_d;
  logic [31:0]            sample_cnt_q, sample_cnt_d;

  logic                   last_word;
  logic                   load_drain;
  logic                   capture;
  logic [WORDS-1:0][DATA_WIDTH-1:0] drain_words;

  assign last_word = (word_idx_q == IDX_W'(WORDS - 1));

  // Burst sequencing: moves pending into drain and steps word_idx on rd_ack.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    drain_d    = drain_q;
    load_drain = 1'b0;
    if (!acq_ena) begin
      state_d    = ST_EMPTY;
      word_idx_d = '0;
      drain_d    = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          word_idx_d = '0;
          if (pending_v_q) begin
            load_drain = 1'b1;
            drain_d    = pending_q;
            state_d    = ST_READY;
          end
        end
        ST_READY: begin
          if (rd_ack) begin
            word_idx_d = IDX_W'(1);
            state_d    = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (rd_ack) begin
            if (last_word) begin
              word_idx_d = '0;
              if (pending_v_q) begin
                load_drain = 1'b1;
                drain_d    = pending_q;
                state_d    = ST_READY;
              end else begin
                state_d = ST_EMPTY;
              end
            end else begin
              word_idx_d = word_idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          word_idx_d = '0;
        end
      endcase
    end
  end

  // Decimation and capture into pending; a transfer into drain in the same
  // cycle frees pending first, so that capture is accepted rather than dropped.
  always_comb begin
    pending_d    = pending_q;
    pending_v_d  = pending_v_q;
    dec_cnt_d    = dec_cnt_q;
    overrun_d    = overrun_q;
    sample_cnt_d = sample_cnt_q;
    capture      = 1'b0;
    if (!acq_ena) begin
      pending_d    = '0;
      pending_v_d  = 1'b0;
      dec_cnt_d    = '0;
      overrun_d    = 1'b0;
      sample_cnt_d = '0;
    end else begin
      if (load_drain) begin
        pending_v_d = 1'b0;
      end
      if (adc_valid) begin
        if (dec_cnt_q == decim) begin
          dec_cnt_d = '0;
          capture   = 1'b1;
        end else begin
          dec_cnt_d = dec_cnt_q + DECIM_WIDTH'(1);
        end
      end
      if (capture) begin
        if (!pending_v_q || load_drain) begin
          pending_d    = adc_data;
          pending_v_d  = 1'b1;
          sample_cnt_d = sample_cnt_q + 32'd1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  // State and buffer registers; everything clears on the async reset.
  always_ff @(posedge data_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      state_q      <= ST_EMPTY;
      word_idx_q   <= '0;
      drain_q      <= '0;
      pending_q    <= '0;
      pending_v_q  <= 1'b0;
      dec_cnt_q    <= '0;
      overrun_q    <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      drain_q      <= drain_d;
      pending_q    <= pending_d;
      pending_v_q  <= pending_v_d;
      dec_cnt_q    <= dec_cnt_d;
      overrun_q    <= overrun_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Word k is drain[k*DATA_WIDTH +: DATA_WIDTH]; selected with no added latency.
  assign drain_words = drain_q;
  assign word_data   = drain_words[word_idx_q];
  assign word_idx    = word_idx_q;
  assign new_sample  = (state_q == ST_READY);
  assign overrun     = overrun_q;
  assign sample_cnt  = sample_cnt_q;

endmodule
